// File: rtl/hiscore_pkg.sv
// Shared types and Blockade defaults for the high-score RAM upload block.
package hiscore_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StSend,
    StSum,
    StDone
  } state_e;

  localparam int unsigned DefaultAddrW   = 8;
  localparam int unsigned DefaultStart   = 0;
  localparam int unsigned DefaultLength  = 256;
  localparam int unsigned DefaultUpAddrW = 14;

endpackage

// File: rtl/hiscore_dump.sv
// Streams a window of the static RAM to the HPS as an addr/data/valid sequence while pausing
// the CPU. Define HISCORE_CHECKSUM_EN to append an 8-bit wrapping sum byte at up_addr=LENGTH.
module hiscore_dump
  import hiscore_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefaultAddrW,
  parameter int unsigned START     = DefaultStart,
  parameter int unsigned LENGTH    = DefaultLength,
  parameter int unsigned UP_ADDR_W = DefaultUpAddrW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  output logic [ADDR_W-1:0]    ram_addr_o,
  output logic                 ram_rd_o,
  input  logic [7:0]           ram_data_i,
  output logic [UP_ADDR_W-1:0] up_addr_o,
  output logic [7:0]           up_data_o,
  output logic                 up_valid_o,
  input  logic                 up_ready_i,
  output logic                 busy_o,
  output logic                 pause_o,
  output logic                 done_o
);

  // One extra bit so that a full 2^ADDR_W window does not wrap the index.
  localparam int unsigned       IdxW      = ADDR_W + 1;
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(LENGTH - 1);
  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START);

  state_e                 state_q;
  logic [IdxW-1:0]        idx_q;
  logic [ADDR_W-1:0]      ram_addr_q;
  logic                   ram_rd_q;
  logic [UP_ADDR_W-1:0]   up_addr_q;
  logic [7:0]             up_data_q;
  logic                   up_valid_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef HISCORE_CHECKSUM_EN
  logic [7:0]             sum_q;
`endif

  logic xfer;
  assign xfer = up_valid_q & up_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      up_addr_q  <= '0;
      up_data_q  <= '0;
      up_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef HISCORE_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      ram_rd_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            idx_q      <= '0;
`ifdef HISCORE_CHECKSUM_EN
            sum_q      <= '0;
`endif
            ram_addr_q <= StartAddr;
            ram_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StRead;
          end
        end
        StRead: begin
          state_q <= StLatch;
        end
        StLatch: begin
          up_data_q  <= ram_data_i;
          up_addr_q  <= UP_ADDR_W'(idx_q);
`ifdef HISCORE_CHECKSUM_EN
          sum_q      <= sum_q + ram_data_i;
`endif
          up_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (xfer) begin
            up_valid_q <= 1'b0;
            if (idx_q == LastIdx) begin
`ifdef HISCORE_CHECKSUM_EN
              up_valid_q <= 1'b1;
              up_addr_q  <= UP_ADDR_W'(LENGTH);
              up_data_q  <= sum_q;
              state_q    <= StSum;
`else
              done_q     <= 1'b1;
              state_q    <= StDone;
`endif
            end else begin
              // ram_addr wraps on its own width, giving (START+idx) mod 2^ADDR_W.
              idx_q      <= idx_q + IdxW'(1);
              ram_addr_q <= ram_addr_q + ADDR_W'(1);
              ram_rd_q   <= 1'b1;
              state_q    <= StRead;
            end
          end
        end
`ifdef HISCORE_CHECKSUM_EN
        StSum: begin
          if (xfer) begin
            up_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end
        end
`endif
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ram_addr_o = ram_addr_q;
  assign ram_rd_o   = ram_rd_q;
  assign up_addr_o  = up_addr_q;
  assign up_data_o  = up_data_q;
  assign up_valid_o = up_valid_q;
  assign busy_o     = busy_q;
  assign pause_o    = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_hiscore_dump.sv
// Randomized bench for hiscore_dump: a 256-byte wrapping window and a single-byte window,
// each checked cycle by cycle against a byte-list/timing reference model.
module tb_hiscore_dump;

  localparam int unsigned UpW = 14;
`ifdef HISCORE_CHECKSUM_EN
  localparam int Cks = 1;
`else
  localparam int Cks = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           start    [2];
  logic [7:0]     ram_addr [2];
  logic           ram_rd   [2];
  logic [7:0]     ram_data [2];
  logic [UpW-1:0] up_addr  [2];
  logic [7:0]     up_data  [2];
  logic           up_valid [2];
  logic           up_ready [2];
  logic           busy     [2];
  logic           pause    [2];
  logic           done     [2];
  logic [7:0]     mem      [2][256];

  int n_checks = 0;
  int n_errors = 0;

  hiscore_dump #(.ADDR_W(8), .START(254), .LENGTH(256), .UP_ADDR_W(UpW)) u_dut_full (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start[0]),
    .ram_addr_o(ram_addr[0]),
    .ram_rd_o  (ram_rd[0]),
    .ram_data_i(ram_data[0]),
    .up_addr_o (up_addr[0]),
    .up_data_o (up_data[0]),
    .up_valid_o(up_valid[0]),
    .up_ready_i(up_ready[0]),
    .busy_o    (busy[0]),
    .pause_o   (pause[0]),
    .done_o    (done[0])
  );

  hiscore_dump #(.ADDR_W(8), .START(48), .LENGTH(1), .UP_ADDR_W(UpW)) u_dut_one (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start[1]),
    .ram_addr_o(ram_addr[1]),
    .ram_rd_o  (ram_rd[1]),
    .ram_data_i(ram_data[1]),
    .up_addr_o (up_addr[1]),
    .up_data_o (up_data[1]),
    .up_valid_o(up_valid[1]),
    .up_ready_i(up_ready[1]),
    .busy_o    (busy[1]),
    .pause_o   (pause[1]),
    .done_o    (done[1])
  );

  // Registered sram: data for a read strobe appears the following cycle.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_rd[d]) ram_data[d] <= mem[d][ram_addr[d]];
    end
  end

  function automatic int dut_start(input int d);
    return (d == 0) ? 254 : 48;
  endfunction

  function automatic int dut_len(input int d);
    return (d == 0) ? 256 : 1;
  endfunction

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check_eq({tag, "_ram_addr"}, ram_addr[d], 0);
    check_eq({tag, "_ram_rd"}, ram_rd[d], 0);
    check_eq({tag, "_up_addr"}, up_addr[d], 0);
    check_eq({tag, "_up_data"}, up_data[d], 0);
    check_eq({tag, "_up_valid"}, up_valid[d], 0);
    check_eq({tag, "_busy"}, busy[d], 0);
    check_eq({tag, "_pause"}, pause[d], 0);
    check_eq({tag, "_done"}, done[d], 0);
  endtask

  // mode 0: ready always high; 1: random ready and stray start pulses; 2: ready low 5 cycles
  // on byte 1. abort_at >= 0 resets the DUT once that byte is offered.
  task automatic run_dump(input int d, input int mode, input int abort_at, input bit fill_seq);
    logic [7:0] q[$];
    logic [7:0] sum;
    int len, total, n, k, offer_at, stall;
    bit rdy, exp_rd;
    len = dut_len(d);
    sum = '0;
    for (int i = 0; i < 256; i++) mem[d][i] = fill_seq ? 8'(i) : 8'($urandom);
    for (int i = 0; i < len; i++) begin
      q.push_back(mem[d][(dut_start(d) + i) % 256]);
      sum = sum + mem[d][(dut_start(d) + i) % 256];
    end
    if (Cks != 0) q.push_back(sum);
    total = len + Cks;

    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    n = 0;
    k = 0;
    offer_at = 3;
    stall = 0;
    while (k < total) begin
      @(negedge clk);
      n++;
      start[d] = (mode == 1) && ($urandom_range(7) == 0);
      if (n > 4000) begin
        check_eq("dump_timeout", k, total);
        start[d] = 1'b0;
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(1));
        default: begin
          rdy = 1'b1;
          if (k == 1 && n >= offer_at && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end
        end
      endcase
      up_ready[d] = rdy;

      check_eq("busy", busy[d], 1);
      check_eq("pause", pause[d], 1);
      check_eq("done_early", done[d], 0);
      exp_rd = (n == offer_at - 2) && (k < len);
      check_eq("ram_rd", ram_rd[d], exp_rd);
      if (exp_rd) check_eq("ram_addr", ram_addr[d], (dut_start(d) + k) % 256);
      if (n >= offer_at) begin
        check_eq("up_valid", up_valid[d], 1);
        check_eq("up_addr", up_addr[d], k);
        check_eq("up_data", up_data[d], q[k]);
      end else begin
        check_eq("up_valid_gap", up_valid[d], 0);
      end

      if (abort_at >= 0 && k == abort_at && n >= offer_at) begin
        up_ready[d] = 1'b0;
        start[d] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle(d, "abort");
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_no_done", done[d], 0);
        check_eq("abort_stay_idle", busy[d], 0);
        return;
      end

      if (n >= offer_at && rdy) begin
        k++;
        offer_at = (k == len) ? n + 1 : n + 3;
      end
    end

    @(negedge clk);
    n++;
    start[d] = 1'b0;
    up_ready[d] = 1'b0;
    check_eq("done_pulse", done[d], 1);
    check_eq("busy_at_done", busy[d], 1);
    check_eq("valid_at_done", up_valid[d], 0);
    if (mode == 0) check_eq("done_cycle", n, 3 * len + 1 + Cks);
    if (mode == 2) check_eq("done_cycle_stall", n, 3 * len + 1 + Cks + 5);
    @(negedge clk);
    check_eq("done_clear", done[d], 0);
    check_eq("busy_clear", busy[d], 0);
    check_eq("pause_clear", pause[d], 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      up_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    reset = 1'b0;
    // Ready with nothing offered must not disturb an idle block.
    up_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_ready_valid", up_valid[0], 0);
    check_eq("idle_ready_busy", busy[0], 0);
    up_ready[0] = 1'b0;

    run_dump(0, 0, -1, 1'b1);
    run_dump(1, 0, -1, 1'b0);
    run_dump(0, 2, -1, 1'b0);
    run_dump(0, 1, -1, 1'b0);
    run_dump(1, 1, -1, 1'b0);
    run_dump(0, 1, 10, 1'b0);
    run_dump(0, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
